pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Next-PC controller for the Pc register (32-bit PC latched on negedge clk).
//   Chooses each cycle between sequential fetch, branch/jump redirect, trap
//   entry, stall hold and halt. Drives IF/ID and ID/EX flushes after redirects.
//   Captures the exception PC on trap entry.
//   Sits between the fetch stage (pcCur from Pc.outPc) and Pc.inPc.
// PARAMETERS
//   RESET_VECTOR  32'h0000_0000  PC loaded in the first cycle after reset.
//   TRAP_VECTOR   32'h0000_0080  PC loaded on trap entry.
//   PC_STEP       4              Sequential increment, in bytes.
//   FLUSH_CYCLES  2              Cycles flushes stay asserted after a redirect; range 1..7.
// PORTS
//   clk           in   1   Clock. State and epc update on posedge.
//   rst_n         in   1   Asynchronous reset, active-low.
//   pcCur         in   32  Current PC (Pc.outPc).
//   stall         in   1   Hazard stall from ID; hold the PC.
//   branchTaken   in   1   Branch resolved taken in EX.
//   branchTarget  in   32  Branch target address.
//   jump          in   1   Unconditional jump decoded in ID.
//   jumpTarget    in   32  Jump target address.
//   trap          in   1   Exception or syscall request.
//   halt          in   1   Halt request (debug or halt instruction).
//   resume        in   1   Leave the HALTED state.
//   pcNext        out  32  Next PC; drives Pc.inPc. Combinational.
//   pcWrite       out  1   1 when pcNext differs from pcCur by intent; 0 when holding.
//   flushIfId     out  1   Squash the IF/ID register.
//   flushIdEx     out  1   Squash the ID/EX register.
//   epc           out  32  PC of the trapping instruction.
//   halted        out  1   1 while in the HALTED state.
// BEHAVIOUR
//   States:
//     BOOT=0, RUN=1, FLUSH=2, HALTED=3. State and the 3-bit flush counter fcnt
//     are registered on posedge clk.
//   Reset (rst_n=0, async):
//     - state=BOOT, fcnt=0, epc=0.
//     - Outputs: pcNext=RESET_VECTOR, pcWrite=1, flush*=0, halted=0.
//   BOOT:
//     - pcNext=RESET_VECTOR, pcWrite=1.
//     - Moves to RUN on the next posedge regardless of inputs.
//   Priority in RUN: trap > branchTaken > jump > halt > stall > sequential.
//     - trap: pcNext=TRAP_VECTOR, epc<=pcCur. Then FLUSH with fcnt=FLUSH_CYCLES.
//     - branchTaken: pcNext=branchTarget. Then FLUSH with fcnt=FLUSH_CYCLES.
//     - jump: pcNext=jumpTarget. Then FLUSH with fcnt=1; only IF/ID is flushed.
//     - halt: pcNext=pcCur, pcWrite=0. Then HALTED.
//     - stall: pcNext=pcCur, pcWrite=0. Stay in RUN.
//     - otherwise: pcNext=pcCur+PC_STEP, pcWrite=1.
//   FLUSH:
//     - flushIfId=1. flushIdEx=1 unless entered by jump.
//     - fcnt decrements each cycle; leaves to RUN when fcnt reaches 1.
//     - pcNext=pcCur+PC_STEP; stall is ignored.
//     - branchTaken and jump are ignored (they come from squashed slots).
//     - trap is honoured: reload TRAP_VECTOR, epc<=pcCur, fcnt=FLUSH_CYCLES.
//   HALTED:
//     - pcWrite=0, pcNext=pcCur, halted=1.
//     - resume -> RUN, taking effect the next cycle.
//     - trap wakes directly to the trap path (same as RUN), even without resume.
//   Flush outputs are Moore: decoded from state only, so they assert the cycle
//     after the redirect decision.
//   Arithmetic: pcCur+PC_STEP wraps modulo 2^32, so 32'hFFFF_FFFC -> 32'h0.
//     Targets pass through unmodified; alignment is not checked.
//   Simultaneous events resolve by the priority above. Example: trap+halt
//     takes the trap and the halt is dropped; the requester must re-assert it.
//   Reset mid-FLUSH or mid-HALT: aborts immediately to BOOT. epc clears to 0.
// TESTING
//   1. Reset release, no requests, 4 cycles -> pcNext 0,4,8,C; flushes stay 0.
//   2. At pcCur=0x10, branchTaken with branchTarget=0x40
//      -> pcNext=0x40, then flushIfId=flushIdEx=1 for 2 cycles,
//      -> then pcNext=0x44,0x48.
//   3. stall=1 for 3 cycles at pcCur=0x20 -> pcWrite=0, pcNext=0x20 held.
//      Release -> 0x24.
//   4. trap+branchTaken+jump in the same cycle at pcCur=0x30 -> pcNext=0x80,
//      epc=0x30, both flushes set. A branch during FLUSH is ignored.
//   5. halt, 5 idle cycles, resume -> halted=1, pcNext frozen during halt;
//      halted=0 and sequential fetch resume one cycle after resume.
//   6. pcCur=0xFFFF_FFFC -> pcNext=0. rst_n low mid-FLUSH -> flushes drop at
//      once, pcNext=RESET_VECTOR.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the pipeline (master) and the next-PC sequencer (slave).
interface pc_sequencer_if;
  logic [31:0] pcCur;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic [31:0] jumpTarget;
  logic        trap;
  logic        halt;
  logic        resume;
  logic [31:0] pcNext;
  logic        pcWrite;
  logic        flushIfId;
  logic        flushIdEx;
  logic [31:0] epc;
  logic        halted;

  modport master (
    output pcCur, stall, branchTaken, branchTarget, jump, jumpTarget, trap, halt, resume,
    input  pcNext, pcWrite, flushIfId, flushIdEx, epc, halted
  );

  modport slave (
    input  pcCur, stall, branchTaken, branchTarget, jump, jumpTarget, trap, halt, resume,
    output pcNext, pcWrite, flushIfId, flushIdEx, epc, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequential fetch, branch/jump redirect, trap entry, stall and halt,
// plus Moore pipeline flushes and exception-PC capture.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter int unsigned PC_STEP      = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic             clk,
  input logic             rst_n,
  pc_sequencer_if.slave   bus
);

  localparam logic [31:0] PcStep    = 32'(PC_STEP);
  localparam logic [2:0]  FlushInit = 3'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StFlush  = 2'd2,
    StHalted = 2'd3
  } state_e;

  state_e      stateQ, stateD;
  logic [2:0]  fcntQ, fcntD;
  logic        jumpFlushQ, jumpFlushD;
  logic [31:0] epcQ, epcD;
  logic        takeTrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ     <= StBoot;
      fcntQ      <= 3'd0;
      jumpFlushQ <= 1'b0;
      epcQ       <= 32'h0;
    end else begin
      stateQ     <= stateD;
      fcntQ      <= fcntD;
      jumpFlushQ <= jumpFlushD;
      epcQ       <= epcD;
    end
  end

  always_comb begin
    stateD      = stateQ;
    fcntD       = fcntQ;
    jumpFlushD  = jumpFlushQ;
    epcD        = epcQ;
    takeTrap    = 1'b0;
    bus.pcNext  = bus.pcCur + PcStep;
    bus.pcWrite = 1'b1;

    unique case (stateQ)
      StBoot: begin
        bus.pcNext = RESET_VECTOR;
        stateD     = StRun;
      end
      StRun: begin
        if (bus.trap) begin
          takeTrap = 1'b1;
        end else if (bus.branchTaken) begin
          bus.pcNext = bus.branchTarget;
          stateD     = StFlush;
          fcntD      = FlushInit;
          jumpFlushD = 1'b0;
        end else if (bus.jump) begin
          // A jump resolves in ID, so only the IF/ID slot holds a wrong-path instruction.
          bus.pcNext = bus.jumpTarget;
          stateD     = StFlush;
          fcntD      = 3'd1;
          jumpFlushD = 1'b1;
        end else if (bus.halt) begin
          bus.pcNext  = bus.pcCur;
          bus.pcWrite = 1'b0;
          stateD      = StHalted;
        end else if (bus.stall) begin
          bus.pcNext  = bus.pcCur;
          bus.pcWrite = 1'b0;
        end
      end
      StFlush: begin
        // Branch/jump/stall here come from squashed slots and are ignored.
        if (bus.trap) begin
          takeTrap = 1'b1;
        end else if (fcntQ <= 3'd1) begin
          stateD = StRun;
        end else begin
          fcntD = fcntQ - 3'd1;
        end
      end
      StHalted: begin
        bus.pcNext  = bus.pcCur;
        bus.pcWrite = 1'b0;
        if (bus.trap) begin
          takeTrap = 1'b1;
        end else if (bus.resume) begin
          stateD = StRun;
        end
      end
      default: begin
        stateD = StBoot;
      end
    endcase

    if (takeTrap) begin
      bus.pcNext  = TRAP_VECTOR;
      bus.pcWrite = 1'b1;
      epcD        = bus.pcCur;
      stateD      = StFlush;
      fcntD       = FlushInit;
      jumpFlushD  = 1'b0;
    end
  end

  always_comb begin
    bus.flushIfId = (stateQ == StFlush);
    bus.flushIdEx = (stateQ == StFlush) && !jumpFlushQ;
    bus.halted    = (stateQ == StHalted);
    bus.epc       = epcQ;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer with hand-written reset corner cases.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0080),
    .PC_STEP     (4),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request bits: stall, branch, jump, trap, halt, resume
  localparam logic [5:0] S = 6'b100000;
  localparam logic [5:0] B = 6'b010000;
  localparam logic [5:0] J = 6'b001000;
  localparam logic [5:0] T = 6'b000100;
  localparam logic [5:0] H = 6'b000010;
  localparam logic [5:0] R = 6'b000001;

  typedef struct {
    logic [31:0] pcCur;
    logic [5:0]  req;
    logic [31:0] branchTarget;
    logic [31:0] jumpTarget;
    logic [31:0] expPcNext;
    logic [3:0]  expFlags; // pcWrite, flushIfId, flushIdEx, halted
    logic [31:0] expEpc;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mkVec(input logic [31:0] pc, input logic [5:0] req,
                                 input logic [31:0] bt, input logic [31:0] jt,
                                 input logic [31:0] expNext, input logic [3:0] flags,
                                 input logic [31:0] expEpc);
    vec_t v;
    v.pcCur        = pc;
    v.req          = req;
    v.branchTarget = bt;
    v.jumpTarget   = jt;
    v.expPcNext    = expNext;
    v.expFlags     = flags;
    v.expEpc       = expEpc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyVec(input vec_t v);
    bus.pcCur        = v.pcCur;
    bus.stall        = v.req[5];
    bus.branchTaken  = v.req[4];
    bus.jump         = v.req[3];
    bus.trap         = v.req[2];
    bus.halt         = v.req[1];
    bus.resume       = v.req[0];
    bus.branchTarget = v.branchTarget;
    bus.jumpTarget   = v.jumpTarget;
  endtask

  task automatic clearReqs();
    bus.stall       = 1'b0;
    bus.branchTaken = 1'b0;
    bus.jump        = 1'b0;
    bus.trap        = 1'b0;
    bus.halt        = 1'b0;
    bus.resume      = 1'b0;
  endtask

  task automatic checkOutputs(input string tag, input vec_t v);
    check({tag, ".pcNext"},    bus.pcNext,           v.expPcNext);
    check({tag, ".pcWrite"},   32'(bus.pcWrite),     32'(v.expFlags[3]));
    check({tag, ".flushIfId"}, 32'(bus.flushIfId),   32'(v.expFlags[2]));
    check({tag, ".flushIdEx"}, 32'(bus.flushIdEx),   32'(v.expFlags[1]));
    check({tag, ".halted"},    32'(bus.halted),      32'(v.expFlags[0]));
    check({tag, ".epc"},       bus.epc,              v.expEpc);
  endtask

  initial begin
    vec_t resetExp;

    // Reset release, sequential fetch
    vecs.push_back(mkVec(32'h100, 6'd0, 0, 0, 32'h0,  4'b1000, 32'h0));
    vecs.push_back(mkVec(32'h0,   6'd0, 0, 0, 32'h4,  4'b1000, 32'h0));
    vecs.push_back(mkVec(32'h4,   6'd0, 0, 0, 32'h8,  4'b1000, 32'h0));
    vecs.push_back(mkVec(32'h8,   6'd0, 0, 0, 32'hC,  4'b1000, 32'h0));
    vecs.push_back(mkVec(32'hC,   6'd0, 0, 0, 32'h10, 4'b1000, 32'h0));
    // Branch redirect, stall and branch ignored while flushing
    vecs.push_back(mkVec(32'h10, B, 32'h40,  0, 32'h40, 4'b1000, 32'h0));
    vecs.push_back(mkVec(32'h40, S, 0,       0, 32'h44, 4'b1110, 32'h0));
    vecs.push_back(mkVec(32'h44, B, 32'h200, 0, 32'h48, 4'b1110, 32'h0));
    vecs.push_back(mkVec(32'h48, 6'd0, 0,    0, 32'h4C, 4'b1000, 32'h0));
    // Stall hold
    for (int i = 0; i < 3; i++) vecs.push_back(mkVec(32'h20, S, 0, 0, 32'h20, 4'b0000, 32'h0));
    vecs.push_back(mkVec(32'h20, 6'd0, 0, 0, 32'h24, 4'b1000, 32'h0));
    // Jump flushes IF/ID only, for one cycle
    vecs.push_back(mkVec(32'h24,  J, 0, 32'h100, 32'h100, 4'b1000, 32'h0));
    vecs.push_back(mkVec(32'h100, 6'd0, 0, 0,    32'h104, 4'b1100, 32'h0));
    vecs.push_back(mkVec(32'h104, 6'd0, 0, 0,    32'h108, 4'b1000, 32'h0));
    // Trap beats branch, jump and halt; branch during flush ignored; halt dropped
    vecs.push_back(mkVec(32'h30, T | B | J | H, 32'h300, 32'h400, 32'h80, 4'b1000, 32'h0));
    vecs.push_back(mkVec(32'h80, B, 32'h500, 0, 32'h84, 4'b1110, 32'h30));
    vecs.push_back(mkVec(32'h84, 6'd0, 0, 0,    32'h88, 4'b1110, 32'h30));
    vecs.push_back(mkVec(32'h88, 6'd0, 0, 0,    32'h8C, 4'b1000, 32'h30));
    // Trap honoured inside a jump flush
    vecs.push_back(mkVec(32'h8C,  J, 0, 32'h600, 32'h600, 4'b1000, 32'h30));
    vecs.push_back(mkVec(32'h600, T, 0, 0,       32'h80,  4'b1100, 32'h30));
    vecs.push_back(mkVec(32'h80,  6'd0, 0, 0,    32'h84,  4'b1110, 32'h600));
    vecs.push_back(mkVec(32'h84,  6'd0, 0, 0,    32'h88,  4'b1110, 32'h600));
    vecs.push_back(mkVec(32'h88,  6'd0, 0, 0,    32'h8C,  4'b1000, 32'h600));
    // Halt, idle, resume
    vecs.push_back(mkVec(32'h8C, H, 0, 0, 32'h8C, 4'b0000, 32'h600));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mkVec(32'h8C, (i == 2) ? S : 6'd0, 0, 0, 32'h8C, 4'b0001, 32'h600));
    vecs.push_back(mkVec(32'h8C, R,    0, 0, 32'h8C, 4'b0001, 32'h600));
    vecs.push_back(mkVec(32'h8C, 6'd0, 0, 0, 32'h90, 4'b1000, 32'h600));
    // Trap wakes from HALTED without resume
    vecs.push_back(mkVec(32'h90, H,    0, 0, 32'h90, 4'b0000, 32'h600));
    vecs.push_back(mkVec(32'h90, T,    0, 0, 32'h80, 4'b1001, 32'h600));
    vecs.push_back(mkVec(32'h80, 6'd0, 0, 0, 32'h84, 4'b1110, 32'h90));
    vecs.push_back(mkVec(32'h84, 6'd0, 0, 0, 32'h88, 4'b1110, 32'h90));
    // Wraparound
    vecs.push_back(mkVec(32'hFFFF_FFFC, 6'd0, 0, 0, 32'h0, 4'b1000, 32'h90));
    vecs.push_back(mkVec(32'h0,         6'd0, 0, 0, 32'h4, 4'b1000, 32'h90));

    resetExp = mkVec(32'h0, 6'd0, 0, 0, 32'h0, 4'b1000, 32'h0);

    rst_n = 1'b0;
    bus.pcCur = 32'h0;
    bus.branchTarget = 32'h0;
    bus.jumpTarget = 32'h0;
    clearReqs();
    repeat (2) @(negedge clk);
    bus.pcCur = 32'h1234;
    bus.trap  = 1'b1;
    #1;
    checkOutputs("reset", resetExp);
    clearReqs();

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyVec(vecs[i]);
      @(negedge clk);
      checkOutputs($sformatf("vec%0d", i), vecs[i]);
      @(posedge clk);
      #1;
    end

    // Reset asserted mid-FLUSH
    clearReqs();
    bus.pcCur = 32'h200;
    bus.branchTaken = 1'b1;
    bus.branchTarget = 32'h300;
    @(posedge clk);
    #1;
    clearReqs();
    bus.pcCur = 32'h300;
    check("midFlush.flushIfId", 32'(bus.flushIfId), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutputs("rstFlush", resetExp);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("boot.pcNext", bus.pcNext, 32'h0);

    // Reset asserted mid-HALT
    @(posedge clk);
    #1;
    bus.halt = 1'b1;
    @(posedge clk);
    #1;
    bus.halt = 1'b0;
    check("midHalt.halted", 32'(bus.halted), 32'd1);
    check("midHalt.pcNext", bus.pcNext, 32'h300);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutputs("rstHalt", resetExp);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
